// File: rtl/up_control.sv
// up_control: fetch/decode/execute sequencer for the 8-bit micro datapath.
// Define UP_CONTROL_STACK_EN to enable PUSH (C) and POP (D); otherwise they are NOPs.
module up_control (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic [3:0] ir,
    input  logic       mem_ack,
    output logic [4:0] op,
    output logic       ir_we,
    output logic       pc_we,
    output logic       rb_we,
    output logic       sp_we,
    output logic [2:0] rb_sel_in,
    output logic       addr_le,
    output logic       bus_sel,
    output logic       mem_req,
    output logic       mem_we,
    output logic       halted
);

    localparam logic [4:0] OP_PASS = 5'b10100;
    localparam logic [4:0] OP_PC   = 5'b10001;
    localparam logic [4:0] OP_R0   = 5'b00110;
    localparam logic [4:0] OP_R3   = 5'b01001;
    localparam logic [4:0] OP_SPDN = 5'b10000;
    localparam logic [4:0] OP_SPUP = 5'b01111;

    localparam logic [2:0] SEL_MEM = 3'b000;
    localparam logic [2:0] SEL_R0  = 3'b100;
    localparam logic [2:0] SEL_R1  = 3'b101;
    localparam logic [2:0] SEL_R2  = 3'b110;
    localparam logic [2:0] SEL_R3  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        F_ADDR,
        F_WAIT,
        INC,
        EXEC,
        M_WAIT,
        HALT
    } state_t;

    state_t state;
    state_t next_state;

    // Direction of the pending data access, captured when leaving EXEC
    logic mem_wr;
    logic mem_wr_next;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= IDLE;
            mem_wr <= 1'b0;
        end else begin
            state  <= next_state;
            mem_wr <= mem_wr_next;
        end
    end

    always_comb begin
        next_state  = state;
        mem_wr_next = mem_wr;
        op          = OP_PASS;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        rb_we       = 1'b0;
        sp_we       = 1'b0;
        rb_sel_in   = 3'b000;
        addr_le     = 1'b0;
        bus_sel     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        halted      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) next_state = F_ADDR;
            end

            F_ADDR: begin
                op         = OP_PC;
                addr_le    = 1'b1;
                next_state = F_WAIT;
            end

            F_WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we      = 1'b1;
                    next_state = INC;
                end
            end

            INC: begin
                bus_sel    = 1'b1;
                pc_we      = 1'b1;
                next_state = EXEC;
            end

            EXEC: begin
                next_state = F_ADDR;
                case (ir)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                        op        = {1'b0, ir};
                        rb_sel_in = SEL_R0;
                        rb_we     = 1'b1;
                    end
                    4'h6: begin
                        op        = {1'b0, ir};
                        rb_sel_in = SEL_R1;
                        rb_we     = 1'b1;
                    end
                    4'h7: begin
                        op        = {1'b0, ir};
                        rb_sel_in = SEL_R2;
                        rb_we     = 1'b1;
                    end
                    4'h8: begin
                        op        = {1'b0, ir};
                        rb_sel_in = SEL_R3;
                        rb_we     = 1'b1;
                    end
                    4'h9: begin
                        op        = OP_R3;
                        rb_sel_in = SEL_R0;
                        rb_we     = 1'b1;
                    end
                    4'hA: begin
                        op          = OP_R3;
                        addr_le     = 1'b1;
                        mem_wr_next = 1'b0;
                        next_state  = M_WAIT;
                    end
                    4'hB: begin
                        op          = OP_R3;
                        addr_le     = 1'b1;
                        mem_wr_next = 1'b1;
                        next_state  = M_WAIT;
                    end
`ifdef UP_CONTROL_STACK_EN
                    4'hC: begin
                        op          = OP_SPDN;
                        sp_we       = 1'b1;
                        addr_le     = 1'b1;
                        mem_wr_next = 1'b1;
                        next_state  = M_WAIT;
                    end
                    4'hD: begin
                        op          = OP_SPUP;
                        sp_we       = 1'b1;
                        addr_le     = 1'b1;
                        mem_wr_next = 1'b0;
                        next_state  = M_WAIT;
                    end
`endif
                    4'hE: begin
                        op    = OP_R3;
                        pc_we = 1'b1;
                    end
                    4'hF: begin
                        next_state = HALT;
                    end
                    default: begin
                        next_state = F_ADDR;
                    end
                endcase
            end

            M_WAIT: begin
                mem_req = 1'b1;
                if (mem_wr) begin
                    op     = OP_R0;
                    mem_we = 1'b1;
                end
                if (mem_ack) begin
                    if (!mem_wr) begin
                        rb_sel_in = SEL_MEM;
                        rb_we     = 1'b1;
                    end
                    next_state = F_ADDR;
                end
            end

            HALT: begin
                halted = 1'b1;
                if (start) next_state = F_ADDR;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_up_control.sv
// Self-checking bench for up_control: directed vector table, instruction-level
// reference traces with random waits, and an asynchronous reset mid-access.
module tb_up_control;

    logic       clk = 1'b0;
    logic       nRst;
    logic       start;
    logic [3:0] ir;
    logic       mem_ack;
    logic [4:0] op;
    logic       ir_we;
    logic       pc_we;
    logic       rb_we;
    logic       sp_we;
    logic [2:0] rb_sel_in;
    logic       addr_le;
    logic       bus_sel;
    logic       mem_req;
    logic       mem_we;
    logic       halted;

    always #5 clk = ~clk;

    up_control dut (
        .clk       (clk),
        .nRst      (nRst),
        .start     (start),
        .ir        (ir),
        .mem_ack   (mem_ack),
        .op        (op),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .rb_we     (rb_we),
        .sp_we     (sp_we),
        .rb_sel_in (rb_sel_in),
        .addr_le   (addr_le),
        .bus_sel   (bus_sel),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .halted    (halted)
    );

`ifdef UP_CONTROL_STACK_EN
    localparam bit STACK = 1'b1;
`else
    localparam bit STACK = 1'b0;
`endif

    localparam logic [4:0] DEFOP = 5'b10100;

    typedef struct packed {
        logic [4:0] op;
        logic       ir_we;
        logic       pc_we;
        logic       rb_we;
        logic       sp_we;
        logic [2:0] rb_sel_in;
        logic       addr_le;
        logic       bus_sel;
        logic       mem_req;
        logic       mem_we;
        logic       halted;
    } out_t;

    typedef struct packed {
        logic       start;
        logic       ack;
        logic [3:0] ir;
        out_t       exp;
    } vec_t;

    out_t got;
    assign got = {op, ir_we, pc_we, rb_we, sp_we, rb_sel_in,
                  addr_le, bus_sel, mem_req, mem_we, halted};

    vec_t vq[$];
    vec_t tbl[15];
    int   n_cmp = 0;
    int   n_bad = 0;

    // flags: i=ir_we p=pc_we r=rb_we s=sp_we a=addr_le b=bus_sel
    //        m=mem_req w=mem_we h=halted
    function automatic out_t o_(logic [4:0] o, logic [2:0] sel, string f);
        out_t r;
        r = '0;
        r.op = o;
        r.rb_sel_in = sel;
        for (int k = 0; k < f.len(); k++) begin
            case (f[k])
                "i": r.ir_we = 1'b1;
                "p": r.pc_we = 1'b1;
                "r": r.rb_we = 1'b1;
                "s": r.sp_we = 1'b1;
                "a": r.addr_le = 1'b1;
                "b": r.bus_sel = 1'b1;
                "m": r.mem_req = 1'b1;
                "w": r.mem_we = 1'b1;
                "h": r.halted = 1'b1;
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic bit is_mem(logic [3:0] i);
        return (i == 4'hA) || (i == 4'hB) ||
               (STACK && ((i == 4'hC) || (i == 4'hD)));
    endfunction

    function automatic out_t exec_exp(logic [3:0] i);
        if (i <= 4'd5) return o_({1'b0, i}, 3'b100, "r");
        if (i <= 4'd8) return o_({1'b0, i}, 3'(i - 4'd1), "r");
        if (i == 4'h9) return o_(5'b01001, 3'b100, "r");
        if (i == 4'hA || i == 4'hB) return o_(5'b01001, 3'b000, "a");
        if (i == 4'hC) return STACK ? o_(5'b10000, 3'b000, "sa") : o_(DEFOP, 3'b000, "");
        if (i == 4'hD) return STACK ? o_(5'b01111, 3'b000, "sa") : o_(DEFOP, 3'b000, "");
        if (i == 4'hE) return o_(5'b01001, 3'b000, "p");
        return o_(DEFOP, 3'b000, "");
    endfunction

    function automatic bit rb();
        return 1'($urandom % 2);
    endfunction

    task automatic push(bit s, bit a, logic [3:0] i, out_t e);
        vq.push_back(vec_t'({s, a, i, e}));
    endtask

    // Cycle-by-cycle expected trace of one instruction, starting at fetch.
    task automatic gen_instr(logic [3:0] i, int w1, int w2, int hc);
        logic [3:0] junk;
        bit wr;
        out_t e;
        junk = 4'($urandom);
        push(rb(), rb(), junk, o_(5'b10001, 3'b000, "a"));
        repeat (w1) push(rb(), 1'b0, junk, o_(DEFOP, 3'b000, "m"));
        push(rb(), 1'b1, junk, o_(DEFOP, 3'b000, "mi"));
        push(rb(), rb(), i, o_(DEFOP, 3'b000, "bp"));
        push(rb(), rb(), i, exec_exp(i));
        if (is_mem(i)) begin
            wr = (i == 4'hB) || (i == 4'hC);
            e = wr ? o_(5'b00110, 3'b000, "mw") : o_(DEFOP, 3'b000, "m");
            repeat (w2) push(rb(), 1'b0, i, e);
            push(rb(), 1'b1, i, wr ? e : o_(DEFOP, 3'b000, "mr"));
        end
        if (i == 4'hF) begin
            repeat (hc) push(1'b0, rb(), i, o_(DEFOP, 3'b000, "h"));
            push(1'b1, rb(), i, o_(DEFOP, 3'b000, "h"));
        end
    endtask

    task automatic check(string nm, int k, out_t e);
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, k, got, e);
        end
    endtask

    task automatic run_q(string nm);
        foreach (vq[k]) begin
            start   = vq[k].start;
            mem_ack = vq[k].ack;
            ir      = vq[k].ir;
            #1;
            check(nm, k, vq[k].exp);
            @(posedge clk);
            #1;
        end
        vq.delete();
    endtask

    initial begin
        logic [3:0] ri;
        out_t d;
        d = o_(DEFOP, 3'b000, "");

        for (int k = 0; k < 10; k++) tbl[k] = vec_t'({1'b0, 1'b0, 4'h0, d});
        tbl[10] = vec_t'({1'b1, 1'b0, 4'h0, d});
        tbl[11] = vec_t'({1'b0, 1'b0, 4'h0, o_(5'b10001, 3'b000, "a")});
        tbl[12] = vec_t'({1'b0, 1'b1, 4'h0, o_(DEFOP, 3'b000, "mi")});
        tbl[13] = vec_t'({1'b0, 1'b0, 4'h0, o_(DEFOP, 3'b000, "bp")});
        tbl[14] = vec_t'({1'b0, 1'b0, 4'h0, o_(5'b00000, 3'b100, "r")});

        nRst = 1'b0;
        start = 1'b0;
        mem_ack = 1'b0;
        ir = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset", 0, d);
        nRst = 1'b1;

        foreach (tbl[k]) vq.push_back(tbl[k]);
        run_q("plan_add");

        gen_instr(4'hA, 0, 3, 0); run_q("ld_wait3");
        gen_instr(4'hC, 1, 2, 0); run_q("push");
        gen_instr(4'hD, 0, 0, 0); run_q("pop");
        gen_instr(4'hB, 2, 1, 0); run_q("st");
        gen_instr(4'hE, 0, 0, 0); run_q("jmp");
        gen_instr(4'h9, 0, 0, 0); run_q("mov_r0_r3");
        gen_instr(4'hF, 0, 0, 4); run_q("halt");

        for (int n = 0; n < 120; n++) begin
            ri = 4'($urandom);
            gen_instr(ri, int'($urandom % 3), int'($urandom % 4),
                      1 + int'($urandom % 3));
            run_q("rand");
        end

        gen_instr(4'hB, 0, 5, 0);
        while (vq.size() > 6) void'(vq.pop_back());
        run_q("pre_rst");
        start = 1'b0;
        mem_ack = 1'b0;
        ir = 4'hB;
        #1;
        check("mwait_hold", 0, o_(5'b00110, 3'b000, "mw"));
        nRst = 1'b0;
        #1;
        check("rst_async", 0, d);
        @(posedge clk);
        #1;
        check("rst_held", 0, d);
        nRst = 1'b1;
        push(1'b0, 1'b1, 4'h0, d);
        push(1'b0, 1'b0, 4'h0, d);
        push(1'b1, 1'b0, 4'h0, d);
        gen_instr(4'h3, 0, 0, 0);
        run_q("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
